// File: rtl/dmi_pkg.sv
// Shared DMI widths and encodings used by the debug transport arbiter.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_SUCCESS = 2'd0,
    DMI_RESP_FAILED  = 2'd2,
    DMI_RESP_BUSY    = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } dmi_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first valid requester at or
// after i_ptr, wrapping around. i_ptr must be below N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_valid[(int'(i_ptr) + k) % N]) begin
        o_any                            = 1'b1;
        o_idx                            = IW'((int'(i_ptr) + k) % N);
        o_grant[(int'(i_ptr) + k) % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI port between N_REQ debug transports, one transaction at a
// time, with a response watchdog that answers FAILED for a silent DM.
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             up_req_valid,
  output logic [N_REQ-1:0]             up_req_ready,
  input  logic [N_REQ*DMI_ADDR_W-1:0]  up_req_addr,
  input  logic [N_REQ*2-1:0]           up_req_op,
  input  logic [N_REQ*DMI_DATA_W-1:0]  up_req_data,
  output logic [N_REQ-1:0]             up_resp_valid,
  input  logic [N_REQ-1:0]             up_resp_ready,
  output logic [N_REQ*2-1:0]           up_resp_resp,
  output logic [N_REQ*DMI_DATA_W-1:0]  up_resp_data,
  output logic                         dmi_req_valid,
  input  logic                         dmi_req_ready,
  output logic [DMI_ADDR_W-1:0]        dmi_req_addr,
  output logic [1:0]                   dmi_req_op,
  output logic [DMI_DATA_W-1:0]        dmi_req_data,
  input  logic                         dmi_resp_valid,
  output logic                         dmi_resp_ready,
  input  logic [1:0]                   dmi_resp_resp,
  input  logic [DMI_DATA_W-1:0]        dmi_resp_data,
  output logic                         busy,
  output logic [$clog2(N_REQ)-1:0]     owner,
  output logic                         timeout
);

  localparam int IW    = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

  dmi_arb_state_e        r_state;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         r_owner;
  logic [DMI_ADDR_W-1:0] r_addr;
  logic [1:0]            r_op;
  logic [DMI_DATA_W-1:0] r_data;
  logic [1:0]            r_resp;
  logic [DMI_DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_drain;
  logic                  r_timeout;

  logic [N_REQ-1:0]      w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic [IW-1:0]         w_rr_next;
  logic [N_REQ-1:0]      w_owner_oh;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .i_valid (up_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_rr_next  = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
  assign w_owner_oh = N_REQ'(1) << r_owner;

  // Ready is held low during reset so no request is taken in that cycle.
  assign up_req_ready   = (r_state == ARB_IDLE && !reset) ? w_grant : '0;
  assign up_resp_valid  = (r_state == ARB_RESP) ? w_owner_oh : '0;
  assign dmi_req_valid  = (r_state == ARB_ISSUE);
  assign dmi_req_addr   = r_addr;
  assign dmi_req_op     = r_op;
  assign dmi_req_data   = r_data;
  assign dmi_resp_ready = (r_state == ARB_WAIT) || r_drain;
  assign busy           = (r_state != ARB_IDLE);
  assign owner          = r_owner;
  assign timeout        = r_timeout;

  always_comb begin
    up_resp_resp = '0;
    up_resp_data = '0;
    if (r_state == ARB_RESP) begin
      up_resp_resp[int'(r_owner)*2 +: 2]                   = r_resp;
      up_resp_data[int'(r_owner)*DMI_DATA_W +: DMI_DATA_W] = r_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_addr    <= '0;
      r_op      <= '0;
      r_data    <= '0;
      r_resp    <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_drain   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A late answer to a timed-out request is swallowed, never routed.
      if (r_drain && dmi_resp_valid) r_drain <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_addr   <= up_req_addr[int'(w_idx)*DMI_ADDR_W +: DMI_ADDR_W];
            r_op     <= up_req_op[int'(w_idx)*2 +: 2];
            r_data   <= up_req_data[int'(w_idx)*DMI_DATA_W +: DMI_DATA_W];
            r_owner  <= w_idx;
            r_rr_ptr <= w_rr_next;
            r_state  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (dmi_req_ready) begin
            r_cnt   <= '0;
            r_state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (dmi_resp_valid && !r_drain) begin
            r_resp  <= dmi_resp_resp;
            r_rdata <= dmi_resp_data;
            r_state <= ARB_RESP;
          end else if (WDOG_EN && r_cnt == CNT_LAST) begin
            r_resp    <= DMI_RESP_FAILED;
            r_rdata   <= '0;
            r_drain   <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ARB_RESP;
          end else if (WDOG_EN) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ARB_RESP: begin
          if (up_resp_ready[r_owner]) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: randomized transactions checked against a
// transaction-level model (round-robin picker, DM memory, expected queues).
module tb_dmi_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    up_req_valid, up_req_ready;
  logic [N*7-1:0]  up_req_addr;
  logic [N*2-1:0]  up_req_op;
  logic [N*32-1:0] up_req_data;
  logic [N-1:0]    up_resp_valid, up_resp_ready;
  logic [N*2-1:0]  up_resp_resp;
  logic [N*32-1:0] up_resp_data;
  logic            dmi_req_valid, dmi_req_ready;
  logic [6:0]      dmi_req_addr;
  logic [1:0]      dmi_req_op;
  logic [31:0]     dmi_req_data;
  logic            dmi_resp_valid, dmi_resp_ready;
  logic [1:0]      dmi_resp_resp;
  logic [31:0]     dmi_resp_data;
  logic            busy;
  logic [0:0]      owner;
  logic            timeout;

  dmi_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_req_addr(up_req_addr), .up_req_op(up_req_op), .up_req_data(up_req_data),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
    .up_resp_resp(up_resp_resp), .up_resp_data(up_resp_data),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
    .busy(busy), .owner(owner), .timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state / scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_ptr = 0;
  bit          dm_allow_busy = 1'b1;
  logic [31:0] mem [128];
  logic [6:0]  f_addr [N];
  logic [1:0]  f_op   [N];
  logic [31:0] f_data [N];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];
  int          exp_owner_q [$];

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requester with a pending request at or after the model pointer.
  function automatic int rr_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      up_req_addr[i*7 +: 7]  = f_addr[i];
      up_req_op[i*2 +: 2]    = f_op[i];
      up_req_data[i*32 +: 32] = f_data[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      f_addr[i] = 7'($urandom_range(0, 127));
      f_op[i]   = 2'($urandom_range(0, 2));
      f_data[i] = $urandom();
    end
    drive_fields();
  endtask

  // Behavioural debug module: READ returns memory, WRITE updates it.
  task automatic dm_model(input logic [1:0] op, input logic [6:0] addr,
                          input logic [31:0] wd, output logic [1:0] rc,
                          output logic [31:0] rd);
    rc = (dm_allow_busy && $urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
    rd = 32'h0;
    if (op == 2'd1) rd = mem[addr];
    else if (op == 2'd2 && rc == 2'd0) mem[addr] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    up_req_valid = '0; up_resp_ready = '0; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    exp_q.delete(); exp_resp_q.delete(); exp_owner_q.delete();
  endtask

  // One full transaction; called right after a negedge with the DUT idle.
  task automatic run_txn(input logic [N-1:0] vmask, input int req_stall, input int dm_wait,
                         input int resp_stall, input bit other_valid, input bit stale_first);
    int w, o, acc, exp_o;
    logic [1:0]  rc, exp_r;
    logic [31:0] rd, exp_d;
    w = rr_pick(vmask);
    o = (w + 1) % N;
    up_req_valid = vmask;
    #1;
    n_cmp++;
    if (up_req_ready !== onehot(w)) begin
      n_bad++; $display("FAIL grant: up_req_ready=%b expected %b", up_req_ready, onehot(w));
    end
    acc = cyc;
    model_ptr = (w + 1) % N;
    exp_owner_q.push_back(w);
    @(negedge clk);
    up_req_valid = '0;
    for (int k = 0; k < req_stall; k++) begin
      dmi_req_ready = 1'b0;
      if (other_valid) up_req_valid[o] = 1'b1;
      #1;
      n_cmp++;
      if (dmi_req_valid !== 1'b1 || dmi_req_addr !== f_addr[w] || dmi_req_op !== f_op[w] ||
          dmi_req_data !== f_data[w] || up_req_ready !== '0) begin
        n_bad++;
        $display("FAIL issue_hold: v=%b a=%h op=%h d=%h rdy=%b expected a=%h op=%h d=%h",
                 dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, up_req_ready,
                 f_addr[w], f_op[w], f_data[w]);
      end
      @(negedge clk);
    end
    dmi_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (dmi_req_valid !== 1'b1 || dmi_req_addr !== f_addr[w] || dmi_req_op !== f_op[w] ||
        dmi_req_data !== f_data[w] || owner !== 1'(w) || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL issue: v=%b a=%h op=%h d=%h owner=%0d busy=%b expected a=%h op=%h d=%h owner=%0d",
               dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, owner, busy,
               f_addr[w], f_op[w], f_data[w], w);
    end
    @(negedge clk);
    dmi_req_ready = 1'b0;
    if (stale_first) begin
      dmi_resp_valid = 1'b1; dmi_resp_resp = 2'd0; dmi_resp_data = 32'hBAD0_0000 | $urandom_range(0, 255);
      #1;
      n_cmp++;
      if (dmi_resp_ready !== 1'b1) begin
        n_bad++; $display("FAIL stale_ready: dmi_resp_ready=%b expected 1", dmi_resp_ready);
      end
      @(negedge clk);
      dmi_resp_valid = 1'b0;
    end
    for (int k = 0; k < dm_wait; k++) begin
      #1;
      n_cmp++;
      if (dmi_resp_ready !== 1'b1 || up_resp_valid !== '0 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL wait: resp_ready=%b up_resp_valid=%b timeout=%b expected 1/00/0",
                 dmi_resp_ready, up_resp_valid, timeout);
      end
      @(negedge clk);
    end
    dm_model(f_op[w], f_addr[w], f_data[w], rc, rd);
    exp_q.push_back(rd);
    exp_resp_q.push_back(rc);
    dmi_resp_valid = 1'b1; dmi_resp_resp = rc; dmi_resp_data = rd;
    @(negedge clk);
    dmi_resp_valid = 1'b0;
    #1;
    exp_d = exp_q.pop_front();
    exp_r = exp_resp_q.pop_front();
    exp_o = exp_owner_q.pop_front();
    n_cmp++;
    if (up_resp_valid !== onehot(exp_o) || up_resp_data[exp_o*32 +: 32] !== exp_d ||
        up_resp_resp[exp_o*2 +: 2] !== exp_r || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL resp: valid=%b data=%h resp=%0d timeout=%b expected valid=%b data=%h resp=%0d",
               up_resp_valid, up_resp_data[exp_o*32 +: 32], up_resp_resp[exp_o*2 +: 2], timeout,
               onehot(exp_o), exp_d, exp_r);
    end
    n_cmp++;
    if (cyc - acc !== 3 + req_stall + dm_wait + int'(stale_first)) begin
      n_bad++;
      $display("FAIL latency: got %0d expected %0d", cyc - acc, 3 + req_stall + dm_wait + int'(stale_first));
    end
    for (int k = 0; k < resp_stall; k++) begin
      if (other_valid) up_req_valid[o] = 1'b1;
      #1;
      n_cmp++;
      if (up_resp_valid !== onehot(exp_o) || up_resp_data[exp_o*32 +: 32] !== exp_d ||
          up_req_ready !== '0 || dmi_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL resp_hold: valid=%b data=%h req_ready=%b dmi_req_valid=%b expected %b/%h/00/0",
                 up_resp_valid, up_resp_data[exp_o*32 +: 32], up_req_ready, dmi_req_valid,
                 onehot(exp_o), exp_d);
      end
      @(negedge clk);
    end
    up_resp_ready = onehot(exp_o);
    up_req_valid = '0;
    @(negedge clk);
    up_resp_ready = '0;
    #1;
    n_cmp++;
    if (up_resp_valid !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL release: up_resp_valid=%b busy=%b expected 00/0", up_resp_valid, busy);
    end
  endtask

  // ---------------- feature tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    up_req_valid = 2'b11; up_resp_ready = '0; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0;
    dmi_resp_resp = '0; dmi_resp_data = '0;
    rand_fields();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (up_req_ready !== '0 || up_resp_valid !== '0 || dmi_req_valid !== 1'b0 || dmi_resp_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_handshake: req_ready=%b resp_valid=%b dmi_req_valid=%b dmi_resp_ready=%b expected all 0",
               up_req_ready, up_resp_valid, dmi_req_valid, dmi_resp_ready);
    end
    n_cmp++;
    if (busy !== 1'b0 || owner !== 1'b0 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL reset_status: busy=%b owner=%0d timeout=%b expected 0/0/0", busy, owner, timeout);
    end
    n_cmp++;
    if (dmi_req_addr !== 7'h0 || dmi_req_op !== 2'h0 || dmi_req_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_fields: addr=%h op=%h data=%h expected 0", dmi_req_addr, dmi_req_op, dmi_req_data);
    end
    up_req_valid = '0;
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single();
    dm_allow_busy = 1'b0;
    mem[7'h11] = 32'hDEADBEEF;
    f_addr[0] = 7'h11; f_op[0] = 2'd1; f_data[0] = $urandom();
    drive_fields();
    run_txn(2'b01, 0, 0, 0, 1'b0, 1'b0);
    dm_allow_busy = 1'b1;
  endtask

  task automatic test_contention();
    int w;
    logic [6:0]  sa;
    logic [1:0]  so, rc;
    logic [31:0] sd, rd;
    do_reset();
    rand_fields();
    up_req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      w = rr_pick(2'b11);
      n_cmp++;
      if (w !== t % 2 || up_req_ready !== onehot(w)) begin
        n_bad++;
        $display("FAIL contention_grant[%0d]: up_req_ready=%b model=%0d expected %b", t, up_req_ready, w, onehot(t % 2));
      end
      model_ptr = (w + 1) % N;
      sa = f_addr[w]; so = f_op[w]; sd = f_data[w];
      @(negedge clk);
      f_addr[w] = 7'($urandom_range(0, 127)); f_op[w] = 2'($urandom_range(0, 2)); f_data[w] = $urandom();
      drive_fields();
      #1;
      n_cmp++;
      if (owner !== 1'(w) || dmi_req_valid !== 1'b1 || dmi_req_addr !== sa || dmi_req_op !== so ||
          dmi_req_data !== sd || up_req_ready !== '0) begin
        n_bad++;
        $display("FAIL contention_issue[%0d]: owner=%0d v=%b a=%h op=%h d=%h expected owner=%0d a=%h op=%h d=%h",
                 t, owner, dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, w, sa, so, sd);
      end
      dmi_req_ready = 1'b1;
      @(negedge clk);
      dmi_req_ready = 1'b0;
      dm_model(so, sa, sd, rc, rd);
      dmi_resp_valid = 1'b1; dmi_resp_resp = rc; dmi_resp_data = rd;
      @(negedge clk);
      dmi_resp_valid = 1'b0;
      #1;
      n_cmp++;
      if (up_resp_valid !== onehot(w) || up_resp_data[w*32 +: 32] !== rd || up_resp_resp[w*2 +: 2] !== rc) begin
        n_bad++;
        $display("FAIL contention_resp[%0d]: valid=%b data=%h resp=%0d expected %b/%h/%0d",
                 t, up_resp_valid, up_resp_data[w*32 +: 32], up_resp_resp[w*2 +: 2], onehot(w), rd, rc);
      end
      up_resp_ready = onehot(w);
      @(negedge clk);
      up_resp_ready = '0;
      if (t == 3) up_req_valid = '0;
    end
  endtask

  task automatic test_backpressure();
    rand_fields();
    run_txn(2'b01, 5, 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_resp_stall();
    rand_fields();
    run_txn(2'b10, 0, 1, 4, 1'b1, 1'b0);
  endtask

  task automatic test_timeout(input bit late_in_wait);
    int w;
    w = rr_pick(2'b01);
    rand_fields();
    f_op[0] = 2'd1;
    drive_fields();
    up_req_valid = 2'b01;
    #1;
    n_cmp++;
    if (up_req_ready !== onehot(w)) begin
      n_bad++; $display("FAIL to_grant: up_req_ready=%b expected %b", up_req_ready, onehot(w));
    end
    model_ptr = (w + 1) % N;
    @(negedge clk);
    up_req_valid = '0;
    dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #1;
      n_cmp++;
      if (timeout !== 1'b0 || up_resp_valid !== '0 || dmi_resp_ready !== 1'b1 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL to_wait[%0d]: timeout=%b up_resp_valid=%b resp_ready=%b busy=%b expected 0/00/1/1",
                 k, timeout, up_resp_valid, dmi_resp_ready, busy);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (timeout !== 1'b1 || up_resp_valid !== onehot(w) || up_resp_resp[w*2 +: 2] !== 2'd2 ||
        up_resp_data[w*32 +: 32] !== 32'h0) begin
      n_bad++;
      $display("FAIL to_fire: timeout=%b valid=%b resp=%0d data=%h expected 1/%b/2/0",
               timeout, up_resp_valid, up_resp_resp[w*2 +: 2], up_resp_data[w*32 +: 32], onehot(w));
    end
    up_resp_ready = onehot(w);
    @(negedge clk);
    up_resp_ready = '0;
    #1;
    n_cmp++;
    if (timeout !== 1'b0 || up_resp_valid !== '0 || dmi_resp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL to_drain: timeout=%b up_resp_valid=%b resp_ready=%b expected 0/00/1",
               timeout, up_resp_valid, dmi_resp_ready);
    end
    rand_fields();
    f_op[1] = 2'd1;
    mem[f_addr[1]] = $urandom();
    drive_fields();
    if (late_in_wait) begin
      run_txn(2'b10, 0, 1, 0, 1'b0, 1'b1);
    end else begin
      dmi_resp_valid = 1'b1; dmi_resp_resp = 2'd0; dmi_resp_data = 32'h1234;
      @(negedge clk);
      dmi_resp_valid = 1'b0;
      #1;
      n_cmp++;
      if (dmi_resp_ready !== 1'b0 || up_resp_valid !== '0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL late_discard: resp_ready=%b up_resp_valid=%b busy=%b expected 0/00/0",
                 dmi_resp_ready, up_resp_valid, busy);
      end
      run_txn(2'b10, 0, 0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_watchdog_edge();
    rand_fields();
    run_txn(2'b01, 0, TO - 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    rand_fields();
    f_op[0] = 2'd2;
    drive_fields();
    up_req_valid = 2'b01;
    @(negedge clk);
    up_req_valid = '0;
    dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    up_req_valid = 2'b11;
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || owner !== 1'b0 || dmi_req_valid !== 1'b0 || dmi_resp_ready !== 1'b0 ||
        up_resp_valid !== '0 || timeout !== 1'b0 || up_req_ready !== '0 || dmi_req_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_wait: busy=%b owner=%0d dreq_v=%b dresp_r=%b uresp_v=%b to=%b ureq_r=%b d=%h expected all 0",
               busy, owner, dmi_req_valid, dmi_resp_ready, up_resp_valid, timeout, up_req_ready, dmi_req_data);
    end
    up_req_valid = '0;
    reset = 1'b0;
    model_ptr = 0;
    exp_q.delete(); exp_resp_q.delete(); exp_owner_q.delete();
    rand_fields();
    run_txn(2'b11, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      rand_fields();
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, TO - 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_resp_stall();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_watchdog_edge();
    test_random();
    test_reset_in_wait();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish within 500000 time units");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares one Debug Module Interface (DMI) port between `N_REQ` debug transport requesters, for example the simulation DTM driver and a JTAG DTM. It grants one requester at a time with round-robin priority and forwards exactly one request downstream. It then routes the single response back to the requester that issued it. A response watchdog synthesizes a FAILED response if the debug module never answers, so a hung DM cannot wedge every requester.

## Interface
Parameters:
- `N_REQ`, default 2: number of upstream requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 1024: cycles to wait for a DM response; 0 disables the watchdog.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `up_req_valid` in N_REQ: per-requester request valid.
- `up_req_ready` out N_REQ: per-requester request accept.
- `up_req_addr` in N_REQ*7: DMI address; requester i occupies bits [7i+6:7i].
- `up_req_op` in N_REQ*2: DMI op (0 NOP, 1 READ, 2 WRITE).
- `up_req_data` in N_REQ*32: write data.
- `up_resp_valid` out N_REQ: response valid to the owning requester.
- `up_resp_ready` in N_REQ: response accept.
- `up_resp_resp` out N_REQ*2: response code (0 SUCCESS, 2 FAILED, 3 BUSY).
- `up_resp_data` out N_REQ*32: read data.
- `dmi_req_valid` out 1, `dmi_req_ready` in 1, `dmi_req_addr` out 7, `dmi_req_op` out 2, `dmi_req_data` out 32: downstream request channel.
- `dmi_resp_valid` in 1, `dmi_resp_ready` out 1, `dmi_resp_resp` in 2, `dmi_resp_data` in 32: downstream response channel.
- `busy` out 1: state is not IDLE.
- `owner` out clog2(N_REQ): index of the current or last granted requester.
- `timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The round-robin picker selects the first valid requester at or after `rr_ptr`, wrapping.
  - `up_req_ready[winner]`=1 combinationally; all other readies are 0.
  - On the handshake: capture addr/op/data, set `owner`=winner and `rr_ptr`=winner+1 mod N_REQ, go to ISSUE.
- ISSUE:
  - `dmi_req_valid`=1 with the registered fields; fields are stable until accepted.
  - On `dmi_req_ready`, go to WAIT and clear the watchdog counter.
- WAIT:
  - `dmi_resp_ready`=1.
  - On `dmi_resp_valid` with `drain`=0: capture resp/data, go to RESP.
  - Counter increments each cycle. When it reaches TIMEOUT_CYCLES (nonzero): load resp=2, data=0, set `drain`=1, pulse `timeout`, go to RESP.
- RESP:
  - `up_resp_valid[owner]`=1 with the captured values; all other resp valids are 0.
  - On `up_resp_ready[owner]`, go to IDLE.
- Drain:
  - While `drain`=1, `dmi_resp_ready`=1 in every state.
  - The first `dmi_resp_valid` is consumed and discarded, then `drain` clears.
  - A response consumed this way is never routed upstream, even in WAIT.
- NOP ops are forwarded like any other op.
- Reset mid-transaction: the state returns to IDLE and the in-flight transaction is abandoned without a response. `drain` is cleared.
- Reset values: all valid/ready outputs 0, `dmi_req_*` fields 0, `busy`=0, `owner`=0, `timeout`=0, `rr_ptr`=0, counter 0.

## Timing
- Upstream accept at cycle T gives `dmi_req_valid` at T+1.
- Downstream response accepted at cycle R gives `up_resp_valid` at R+1.
- Minimum turnaround with zero-wait DM: accept T, issue T+1, response T+2, upstream response T+3. The next grant occurs no earlier than the cycle the upstream response handshake completes +1.
- Only one transaction is outstanding at any time.
- `up_req_ready` is 0 outside IDLE; `dmi_resp_ready` is 0 in ISSUE unless `drain`=1.
- The watchdog fires on exactly the TIMEOUT_CYCLES-th cycle spent in WAIT.
- If `dmi_resp_valid` arrives in that same cycle, the real response wins and `timeout` does not pulse.

## Structure
- Shared package `dmi_pkg`:
  - `DMI_ADDR_W`=7, `DMI_DATA_W`=32.
  - Op enum: NOP/READ/WRITE.
  - Response enum: SUCCESS/FAILED/BUSY.
  - `dmi_arb_state_e`.
- Sub-module `rr_arbiter` (parameter N; valid vector and pointer in; one-hot grant and index out). It is purely combinational and reusable.

## Test plan
- Single requester: req0 READ addr 0x11 with DM returning data 0xDEADBEEF → `up_resp_valid[0]` with data 0xDEADBEEF, resp 0, exactly 3 cycles after the accept.
- Contention: req0 and req1 valid continuously from reset → grants alternate 0,1,0,1 over 4 transactions and `owner` tracks each grant.
- Downstream backpressure: `dmi_req_ready` low for 5 cycles → addr/op/data held stable and `up_req_ready` stays 0 throughout.
- Timeout with TIMEOUT_CYCLES=8 and DM silent → `timeout` pulses after 8 WAIT cycles and the owner receives resp 2, data 0. A late DM response of 0x1234 is then consumed and discarded, and the next transaction's data is routed correctly.
- Upstream response stall: `up_resp_ready[1]` low for 4 cycles → `up_resp_valid[1]` and data held stable and no new grant is issued.
- Reset asserted in WAIT → all outputs return to reset values next cycle, and the next request is issued normally with `rr_ptr`=0.
